// File: rtl/dstack_pkg.sv
// Shared types and helpers for the data_stack operand stack.
package dstack_pkg;

   localparam int unsigned DSTACK_WIDTH = 16;

   typedef enum logic [2:0] {
      STK_NOP,
      STK_LOAD,
      STK_PUSH,
      STK_DUP,
      STK_POP,
      STK_POPLOAD,
      STK_ILLEGAL
   } stk_op_t;

   // Priority: push+pop conflict first, then push, then pop, then load alone.
   function automatic stk_op_t decode_stk_op(input logic push, input logic pop,
                                              input logic load_stk);
      stk_op_t op;
      if (push && pop)  op = STK_ILLEGAL;
      else if (push)    op = load_stk ? STK_PUSH : STK_DUP;
      else if (pop)     op = load_stk ? STK_POPLOAD : STK_POP;
      else if (load_stk) op = STK_LOAD;
      else              op = STK_NOP;
      return op;
   endfunction

   // Pointer width for an n-entry array, never below one bit.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_stack_if.sv
// Command/result bundle between the decoder/ALU side and the data stack.
interface data_stack_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned DW = $clog2(DEPTH + 1);

   logic             push;
   logic             pop;
   logic             load_stk;
   logic [WIDTH-1:0] data_in;
   logic             err_clr;
   logic [WIDTH-1:0] stk0;
   logic [WIDTH-1:0] stk1;
   logic [DW-1:0]    depth;
   logic             ovf;
   logic             udf;

   modport master (
      output push, pop, load_stk, data_in, err_clr,
      input  stk0, stk1, depth, ovf, udf
   );

   modport slave (
      input  push, pop, load_stk, data_in, err_clr,
      output stk0, stk1, depth, ovf, udf
   );
endinterface

// File: rtl/data_stack_mem.sv
// Circular spill array below stk1: synchronous write, asynchronous read.
module dstack_mem
   import dstack_pkg::*;
#(
   parameter int unsigned WIDTH = DSTACK_WIDTH,
   parameter int unsigned DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           i_we,
   input  logic [ptr_w(DEPTH-2)-1:0]      i_wptr,
   input  logic [WIDTH-1:0]               i_wdata,
   input  logic [ptr_w(DEPTH-2)-1:0]      i_rptr,
   output logic [WIDTH-1:0]               o_rdata
);
   localparam int unsigned M = DEPTH - 2;

   logic [WIDTH-1:0] r_mem [M];

   // Contents are deliberately not reset; validity is tracked by depth.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_rptr];
endmodule

// File: rtl/data_stack.sv
// Operand stack: stk0/stk1 in flops, deeper entries in a circular dstack_mem.
// Optional sticky ovf/udf flags are built only when DSTACK_ERR_EN is defined.
module data_stack
   import dstack_pkg::*;
#(
   parameter int unsigned WIDTH = DSTACK_WIDTH,
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   data_stack_if.slave   sl
);
   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned M  = DEPTH - 2;
   localparam int unsigned PW = ptr_w(M);

   logic [WIDTH-1:0] r_stk0, r_stk1;
   logic [DW-1:0]    r_depth;
   logic [PW-1:0]    r_wptr;

   logic [WIDTH-1:0] w_stk0_nxt, w_stk1_nxt, w_rdata, w_refill;
   logic [DW-1:0]    w_depth_nxt;
   logic [PW-1:0]    w_wptr_nxt, w_wptr_inc, w_rptr;
   logic             w_we, w_full, w_empty, w_arr_valid, w_ovf_evt, w_udf_evt;
   stk_op_t          w_op;

   assign w_op        = decode_stk_op(sl.push, sl.pop, sl.load_stk);
   assign w_full      = (r_depth == DW'(DEPTH));
   assign w_empty     = (r_depth == '0);
   assign w_arr_valid = (r_depth > DW'(2));
   assign w_wptr_inc  = (r_wptr == PW'(M - 1)) ? '0 : r_wptr + PW'(1);
   assign w_rptr      = (r_wptr == '0) ? PW'(M - 1) : r_wptr - PW'(1);
   assign w_refill    = w_arr_valid ? w_rdata : '0;

   dstack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_wptr  (r_wptr),
      .i_wdata (r_stk1),
      .i_rptr  (w_rptr),
      .o_rdata (w_rdata)
   );

   // Next-state decode; the spill pointer only moves when the array count changes
   // or, at full, when the circular buffer overwrites its oldest entry.
   always_comb begin
      w_stk0_nxt  = r_stk0;
      w_stk1_nxt  = r_stk1;
      w_depth_nxt = r_depth;
      w_wptr_nxt  = r_wptr;
      w_we        = 1'b0;
      w_ovf_evt   = 1'b0;
      w_udf_evt   = 1'b0;
      case (w_op)
         STK_LOAD: w_stk0_nxt = sl.data_in;
         STK_PUSH, STK_DUP: begin
            w_we       = 1'b1;
            w_stk1_nxt = r_stk0;
            if (w_op == STK_PUSH) w_stk0_nxt = sl.data_in;
            if (r_depth >= DW'(2)) w_wptr_nxt = w_wptr_inc;
            if (w_full) w_ovf_evt   = 1'b1;
            else        w_depth_nxt = r_depth + DW'(1);
         end
         STK_POP, STK_POPLOAD: begin
            w_stk0_nxt = (w_op == STK_POPLOAD) ? sl.data_in : r_stk1;
            w_stk1_nxt = w_refill;
            if (w_arr_valid) w_wptr_nxt = w_rptr;
            if (w_empty) w_udf_evt   = 1'b1;
            else         w_depth_nxt = r_depth - DW'(1);
         end
         STK_ILLEGAL: begin
            if (sl.load_stk) w_stk0_nxt = sl.data_in;
            w_ovf_evt = 1'b1;
            w_udf_evt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stk0  <= '0;
         r_stk1  <= '0;
         r_depth <= '0;
         r_wptr  <= '0;
      end else begin
         r_stk0  <= w_stk0_nxt;
         r_stk1  <= w_stk1_nxt;
         r_depth <= w_depth_nxt;
         r_wptr  <= w_wptr_nxt;
      end
   end

`ifdef DSTACK_ERR_EN
   logic r_ovf, r_udf;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (r_ovf & ~sl.err_clr) | w_ovf_evt;
         r_udf <= (r_udf & ~sl.err_clr) | w_udf_evt;
      end
   end

   assign sl.ovf = r_ovf;
   assign sl.udf = r_udf;
`else
   logic w_unused;
   assign w_unused = &{1'b0, sl.err_clr, w_ovf_evt, w_udf_evt};
   assign sl.ovf   = 1'b0;
   assign sl.udf   = 1'b0;
`endif

   assign sl.stk0  = r_stk0;
   assign sl.stk1  = r_stk1;
   assign sl.depth = r_depth;
endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Operand (data) stack directly downstream of the `signals` decoder. It consumes `push`, `pop` and `load_stk`, and takes the ALU result as write data.
- It holds top-of-stack (`stk0`) and next (`stk1`) in flops, which feed ALU operand A/B and the memory write-data path. Deeper entries live in a small register-file array.
- It keeps a depth counter and reports overflow/underflow to the debug/status logic.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, total capacity including `stk0`/`stk1`. Must be ≥ 3.

Ports:
- clk  in  1  system clock; every state element updates on its rising edge.
- rst_n  in  1  reset.
- push  in  1  from decoder: grow stack by one.
- pop  in  1  from decoder: shrink stack by one.
- load_stk  in  1  from decoder: write `data_in` into `stk0`.
- data_in  in  WIDTH  ALU result.
- err_clr  in  1  clear sticky error flags.
- stk0  out  WIDTH  top of stack.
- stk1  out  WIDTH  second entry.
- depth  out  $clog2(DEPTH+1)  number of valid entries.
- ovf  out  1  sticky overflow.
- udf  out  1  sticky underflow.

Interface decision (fixed): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (`rst_n`=0, asynchronous): `stk0`=0, `stk1`=0, `depth`=0, `ovf`=0, `udf`=0. The array is not cleared.
- All updates take effect on the rising `clk` edge. Outputs come straight from flops and are visible in the cycle after the command. Zero combinational path from inputs to outputs.
- Command decode, in priority order:
  - push=1, pop=1: illegal. Treat as load_stk only (or NOP if load_stk=0). `depth` unchanged. Set `udf` and `ovf` both.
  - push=1, load_stk=1 (PUSH imm): array[top] ← `stk1`; `stk1` ← `stk0`; `stk0` ← `data_in`; depth+1.
  - push=1, load_stk=0 (DUP): array[top] ← `stk1`; `stk1` ← `stk0`; `stk0` unchanged; depth+1.
  - pop=1, load_stk=1 (binary op): `stk0` ← `data_in`; `stk1` ← array[top-1]; depth-1.
  - pop=1, load_stk=0 (JZ, ST): `stk0` ← `stk1`; `stk1` ← array[top-1]; depth-1.
  - load_stk=1 only (unary op): `stk0` ← `data_in`; depth unchanged.
  - none asserted: hold all state.
- Array pointer: `top` = max(depth−2, 0). Entries at or above `top` are invalid.
- Refill on pop: when depth ≤ 2 before the pop, the value shifted into `stk1` is 0, not array contents.
- Push at full (`depth`==DEPTH):
  - Operation proceeds; the array is used as a circular buffer, so the oldest entry is overwritten.
  - `depth` saturates at DEPTH.
  - `ovf` ← 1.
- Pop at empty (`depth`==0):
  - `depth` stays 0 and `udf` ← 1.
  - `stk0`/`stk1` update per the rules above (shifted-in values = 0).
- Sticky flags: `ovf`/`udf` hold until `err_clr`=1 or reset. If `err_clr` and a new error occur in the same cycle, the new error wins (flag = 1).
- Reset mid-operation: asynchronous clear takes effect immediately. The first command after `rst_n` rises operates on an empty stack.
- The decoder asserts commands only in exec/rdmem phases. This block needs no phase awareness.

Optional Feature:
- DSTACK_ERR_EN
  - Defined: `ovf`/`udf` are sticky as above and `err_clr` is honoured.
  - Undefined: `ovf`=`udf`=0 constantly, `err_clr` is ignored, and the flag logic is absent. Stack/depth behaviour (saturation, zero refill) is identical.

Decomposition:
- Shared package `dstack_pkg`:
  - typedef enum `stk_op_t` {STK_NOP, STK_LOAD, STK_PUSH, STK_DUP, STK_POP, STK_POPLOAD, STK_ILLEGAL}.
  - function `decode_stk_op(push, pop, load_stk)`.
  - constant DSTACK_WIDTH=16.
- Sub-module `dstack_mem`: (DEPTH−2)×WIDTH array, synchronous write, asynchronous read, write and read pointers wrapping modulo DEPTH−2.

Test Plan:
1. Reset, then push+load 0x00A5, then push+load 0x1234 → `stk0`=0x1234, `stk1`=0x00A5, `depth`=2, `ovf`=`udf`=0.
2. Push 0x0001..0x0005, then pop+load 0x0009 (ADD) → `stk0`=0x0009, `stk1`=0x0003, `depth`=4. Then pop only ×3 → `stk0`=0x0001, `stk1`=0, `depth`=1.
3. From `depth`=1 (`stk0`=0x0007): pop, then pop again → `depth`=0, `stk0`=0, `udf`=1. Then `err_clr`=1 → `udf`=0.
4. Push 17 values 0x0100..0x0110 with DEPTH=16 → `depth`=16, `ovf`=1, `stk0`=0x0110. Then 15 pops → `stk0`=0x0101 and oldest value 0x0100 is lost.
5. Load only 0xBEEF at `depth`=3 → `stk0`=0xBEEF, `stk1` and `depth` unchanged. Push=pop=load=1 with `data_in`=0x5555 → `stk0`=0x5555, `depth` unchanged, `ovf`=`udf`=1.
6. Assert `rst_n`=0 between clock edges while `depth`=5 → outputs go to 0 before the next edge. Build without DSTACK_ERR_EN and rerun scenario 4 → `ovf` stays 0.
